// File: rtl/reg_status_file_pkg.sv
// Shared widths, bus types and constants for the architectural register/rename-tag file.
package reg_status_file_pkg;

    localparam int REG_NUM = 32;
    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 5;

    typedef logic [REG_W-1:0]  RegBus;
    typedef logic [DATA_W-1:0] RegValBus;
    typedef logic [TAG_W-1:0]  ROBTagBus;

    // Tag value meaning "no in-flight producer; the stored value is current".
    localparam ROBTagBus TAG_NONE = '0;

endpackage

// File: rtl/reg_status_file.sv
// Architectural register file with per-register ROB rename tags.
// Optional macro REG_COMMIT_BYPASS_EN forwards a releasing commit to the same-cycle read ports.
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int REG_NUM = reg_status_file_pkg::REG_NUM,
    parameter int DATA_W  = reg_status_file_pkg::DATA_W,
    parameter int TAG_W   = reg_status_file_pkg::TAG_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  RegBus             rs1_addr,
    input  RegBus             rs2_addr,
    output logic [DATA_W-1:0] rs1_val,
    output logic [TAG_W-1:0]  rs1_rely,
    output logic [DATA_W-1:0] rs2_val,
    output logic [TAG_W-1:0]  rs2_rely,
    input  logic              dispatch_rdy,
    input  RegBus             dispatch_rd,
    input  logic [TAG_W-1:0]  rob_next_tag,
    input  logic              write_rdy,
    input  RegBus             to_rd,
    input  logic [DATA_W-1:0] write_val,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic              clear
);

    localparam logic [TAG_W-1:0] TAG_CLR = TAG_W'(TAG_NONE);

    logic [DATA_W-1:0] val_q [REG_NUM];
    logic [DATA_W-1:0] val_d [REG_NUM];
    logic [TAG_W-1:0]  tag_q [REG_NUM];
    logic [TAG_W-1:0]  tag_d [REG_NUM];

    logic commit_en;
    logic rename_en;

    assign commit_en = write_rdy && (to_rd != '0);
    assign rename_en = dispatch_rdy && (dispatch_rd != '0) && !clear;

    function automatic void read_port(
        input  RegBus             addr,
        output logic [DATA_W-1:0] val,
        output logic [TAG_W-1:0]  rely
    );
        val  = val_q[addr];
        rely = tag_q[addr];
`ifdef REG_COMMIT_BYPASS_EN
        if (commit_en && (addr == to_rd) && (tag_q[to_rd] == commit_tag)) begin
            val  = write_val;
            rely = TAG_CLR;
        end
`endif
        if (addr == '0) begin
            val  = '0;
            rely = TAG_CLR;
        end
    endfunction

    always_comb begin
        read_port(rs1_addr, rs1_val, rs1_rely);
        read_port(rs2_addr, rs2_val, rs2_rely);
    end

    // Later statements override earlier ones, giving clear > rename > commit-tag-release.
    always_comb begin
        // NOTE: start from the held state so every element has a value on every path (no latches).
        val_d = val_q;
        tag_d = tag_q;
        if (rdy_in) begin
            if (commit_en) begin
                val_d[to_rd] = write_val;
                if (tag_q[to_rd] == commit_tag) begin
                    tag_d[to_rd] = TAG_CLR;
                end
            end
            if (rename_en) begin
                tag_d[dispatch_rd] = rob_next_tag;
            end
            if (clear) begin
                tag_d = '{default: TAG_CLR};
            end
        end
        val_d[0] = '0;
        tag_d[0] = TAG_CLR;
    end

    // NOTE: both arrays are architectural state that must read back zero after reset, so they are
    // reset here like ordinary flops rather than left to a RAM macro.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            val_q <= '{default: '0};
            tag_q <= '{default: TAG_CLR};
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge state.
            val_q <= val_d;
            tag_q <= tag_d;
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a rule-based model of the register/tag state.
module tb_reg_status_file;
    import reg_status_file_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  rs1_rely, rs2_rely;
    logic        dispatch_rdy;
    logic [4:0]  dispatch_rd;
    logic [4:0]  rob_next_tag;
    logic        write_rdy;
    logic [4:0]  to_rd;
    logic [31:0] write_val;
    logic [4:0]  commit_tag;
    logic        clear;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    always #5 clk_in = ~clk_in;

    reg_status_file dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_val      (rs1_val),
        .rs1_rely     (rs1_rely),
        .rs2_val      (rs2_val),
        .rs2_rely     (rs2_rely),
        .dispatch_rdy (dispatch_rdy),
        .dispatch_rd  (dispatch_rd),
        .rob_next_tag (rob_next_tag),
        .write_rdy    (write_rdy),
        .to_rd        (to_rd),
        .write_val    (write_val),
        .commit_tag   (commit_tag),
        .clear        (clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: what each register holds and which ROB tag (if any) still owns it.
    logic [31:0] m_val [32];
    logic [4:0]  m_tag [32];

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int r = 0; r < 32; r++) begin
                m_val[r] = '0;
                m_tag[r] = '0;
            end
        end else if (rdy_in) begin
            for (int r = 1; r < 32; r++) begin
                if (clear)
                    m_tag[r] = '0;
                else if (dispatch_rdy && dispatch_rd == 5'(r))
                    m_tag[r] = rob_next_tag;
                else if (write_rdy && to_rd == 5'(r) && m_tag[r] == commit_tag)
                    m_tag[r] = '0;
                if (write_rdy && to_rd == 5'(r))
                    m_val[r] = write_val;
            end
        end
    end

    function automatic bit bypass_hit(input logic [4:0] a);
`ifdef REG_COMMIT_BYPASS_EN
        return write_rdy && a != 0 && to_rd == a && m_tag[a] == commit_tag;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_val(input logic [4:0] a);
        if (a == 0) return '0;
        if (bypass_hit(a)) return write_val;
        return m_val[a];
    endfunction

    function automatic logic [31:0] exp_rely(input logic [4:0] a);
        if (a == 0) return '0;
        if (bypass_hit(a)) return '0;
        return 32'(m_tag[a]);
    endfunction

    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("rs1_val",  rs1_val,        exp_val(rs1_addr));
            check("rs1_rely", 32'(rs1_rely),  exp_rely(rs1_addr));
            check("rs2_val",  rs2_val,        exp_val(rs2_addr));
            check("rs2_rely", 32'(rs2_rely),  exp_rely(rs2_addr));
        end
    end

    task automatic idle();
        rdy_in       = 1'b1;
        dispatch_rdy = 1'b0;
        dispatch_rd  = '0;
        rob_next_tag = '0;
        write_rdy    = 1'b0;
        to_rd        = '0;
        write_val    = '0;
        commit_tag   = '0;
        clear        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic rename(input logic [4:0] rd, input logic [4:0] t);
        dispatch_rdy = 1'b1;
        dispatch_rd  = rd;
        rob_next_tag = t;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [4:0] t);
        write_rdy  = 1'b1;
        to_rd      = rd;
        write_val  = v;
        commit_tag = t;
    endtask

    task automatic lit(input string name, input logic [4:0] a,
                       input logic [31:0] ev, input logic [31:0] et);
        rs1_addr = a;
        #1;
        check({name, "_val"},  rs1_val,       ev);
        check({name, "_rely"}, 32'(rs1_rely), et);
    endtask

    initial begin
        rst_in   = 1'b0;
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        idle();
        repeat (2) @(posedge clk_in);
        #1;
        check("reset_rs1_val",  rs1_val,        32'h0);
        check("reset_rs1_rely", 32'(rs1_rely),  32'h0);
        check("reset_rs2_val",  rs2_val,        32'h0);
        check("reset_rs2_rely", 32'(rs2_rely),  32'h0);
        rst_in = 1'b1;
        cmp_en = 1'b1;
        step();

        // Reset arriving while a rename of x5 is in flight discards it.
        rename(5'd5, 5'd3);
        #2 rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        idle();
        rst_in = 1'b1;
        lit("midreset_x5", 5'd5, 32'h0, 32'h0);

        rename(5'd3, 5'd4);                step();
        commit(5'd3, 32'h1234, 5'd4);      step();
        lit("commit_x3", 5'd3, 32'h1234, 32'h0);

        rename(5'd3, 5'd4);                step();
        rename(5'd3, 5'd7);                step();
        commit(5'd3, 32'hAA, 5'd4);        step();
        lit("older_commit_x3", 5'd3, 32'hAA, 32'd7);
        commit(5'd3, 32'hBB, 5'd7);        step();
        lit("younger_commit_x3", 5'd3, 32'hBB, 32'd0);

        rename(5'd8, 5'd2);                step();
        commit(5'd8, 32'h55, 5'd2);
        rename(5'd8, 5'd9);                step();
        lit("same_cycle_x8", 5'd8, 32'h55, 32'd9);

        rename(5'd1, 5'd1);                step();
        rename(5'd2, 5'd2);                step();
        clear = 1'b1;
        commit(5'd1, 32'h10, 5'd1);
        rename(5'd4, 5'd3);                step();
        lit("clear_x1", 5'd1, 32'h10, 32'd0);
        lit("clear_x2", 5'd2, 32'h0,  32'd0);
        lit("clear_x4", 5'd4, 32'h0,  32'd0);

        commit(5'd0, 32'hFF, 5'd0);
        rename(5'd0, 5'd5);
        lit("x0_same_cycle", 5'd0, 32'h0, 32'h0);
        step();
        lit("x0_after", 5'd0, 32'h0, 32'h0);

        rename(5'd6, 5'd3);                step();
        commit(5'd6, 32'h77, 5'd3);
`ifdef REG_COMMIT_BYPASS_EN
        lit("bypass_x6", 5'd6, 32'h77, 32'd0);
`else
        lit("nobypass_x6", 5'd6, 32'h0, 32'd3);
`endif
        step();
        lit("post_commit_x6", 5'd6, 32'h77, 32'd0);

        commit(5'd3, 32'h9999, 5'd0);
        rename(5'd3, 5'd12);
        rdy_in = 1'b0;                     step();
        lit("hold_x3", 5'd3, 32'hBB, 32'd0);

        // Randomized traffic on a small register window so renames and commits collide often.
        for (int i = 0; i < 3000; i++) begin
            rdy_in       = ($urandom % 10) != 0;
            dispatch_rdy = $urandom % 2;
            dispatch_rd  = 5'($urandom % 8);
            rob_next_tag = 5'($urandom_range(1, 16));
            write_rdy    = $urandom % 2;
            to_rd        = 5'($urandom % 8);
            write_val    = $urandom;
            commit_tag   = ($urandom % 2) ? m_tag[to_rd] : 5'($urandom_range(0, 16));
            clear        = ($urandom % 25) == 0;
            rs1_addr     = 5'($urandom % 8);
            rs2_addr     = 5'($urandom % 8);
            if (i == 1500) begin
                #2 rst_in = 1'b0;
                #2 rst_in = 1'b1;
            end
            @(posedge clk_in);
            #1;
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file with per-register rename tags, sitting between dispatch and the ROB commit port.
- Dispatch reads rs1/rs2 value plus producing ROB tag (rely) each cycle, and renames rd to the ROB's next tag.
- ROB commits write values back and release tags; a ROB clear (mispredict) drops all tags.
- rs1_rely/rs2_rely feed the ROB's rs1_rely/rs2_rely lookup inputs.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero)
- DATA_W, 32, register value width
- TAG_W, 5, ROB tag width; tag 0 = "no producer", valid tags 1..16

Ports:
- clk_in  input  1  clock, all state on posedge
- rst_in  input  1  reset, asynchronous, active-low
- rdy_in  input  1  global ready; low = hold all state
- rs1_addr  input  5  dispatch source register 1
- rs2_addr  input  5  dispatch source register 2
- rs1_val  output  DATA_W  committed value of rs1 (combinational)
- rs1_rely  output  TAG_W  ROB tag producing rs1, 0 if committed value valid
- rs2_val  output  DATA_W  as rs1_val for rs2
- rs2_rely  output  TAG_W  as rs1_rely for rs2
- dispatch_rdy  input  1  dispatch issues an instruction this cycle
- dispatch_rd  input  5  destination register, 0 = none
- rob_next_tag  input  TAG_W  ROB tag allocated to the dispatched instruction
- write_rdy  input  1  ROB commit writes a register
- to_rd  input  5  commit destination register
- write_val  input  DATA_W  commit value
- commit_tag  input  TAG_W  ROB tag of the committing entry
- clear  input  1  ROB flush; drop all speculative tags

Behaviour:
- State: val[0..REG_NUM-1] (DATA_W), tag[0..REG_NUM-1] (TAG_W).
- Reset (rst_in=0, asynchronous): all val and tag cleared to 0. Reads then return rs*_val=0 and rs*_rely=0.
- Reset mid-operation: the commit or rename in flight is discarded, with no partial update.
- rdy_in=0: no state change. Combinational reads remain valid.
- Reads are combinational with zero latency. rs*_val=val[addr] and rs*_rely=tag[addr].
- Address 0 always reads val=0, rely=0.
- Commit (write_rdy=1, to_rd!=0), posedge:
  - val[to_rd] <= write_val.
  - If tag[to_rd]==commit_tag, tag[to_rd] <= 0. Otherwise a younger rename owns the register and the tag is kept.
- Rename (dispatch_rdy=1, dispatch_rd!=0, clear=0), posedge: tag[dispatch_rd] <= rob_next_tag.
- Commit and rename to the same rd in one cycle: value written, tag = rob_next_tag (rename wins).
- clear=1, posedge:
  - All tags <= 0, values kept.
  - A commit in the same cycle still writes its value.
  - A rename in the same cycle is ignored.
- Writes to x0 from either port are ignored.
- No FSM; two 32-entry arrays plus priority logic: reset > clear > rename > commit-tag-release.

Optional Feature:
- Macro REG_COMMIT_BYPASS_EN.
- Defined: when write_rdy=1, to_rd!=0, rs*_addr==to_rd and tag[to_rd]==commit_tag, the read returns rs*_val=write_val and rs*_rely=0 in the same cycle.
- Not defined: the read returns the pre-commit val and tag (the ROB lookup still resolves the value). State updates are identical either way.

Decomposition:
- Shared constants package: RegBus (5-bit register index), RegValBus (DATA_W), ROBTagBus (TAG_W), REG_NUM, and tag-none value 0.
- No sub-module; a per-port read mux function (address, bypass) is the only repeated logic.

Test Plan:
- Reset release: read rs1=5, rs2=0 -> val 0/0, rely 0/0. Assert rst_in=0 mid-rename of x5 -> tag[5] stays 0.
- Rename x3 tag 4, next cycle commit x3 val 0x1234 tag 4 -> rs1_addr=3 returns val 0x1234, rely 0.
- Rename x3 tag 4, rename x3 tag 7, commit x3 tag 4 val 0xAA -> val 0xAA, rely 7. Then commit tag 7 val 0xBB -> 0xBB, rely 0.
- Same-cycle commit x8 tag 2 (val 0x55) and rename x8 tag 9 -> val 0x55, rely 9.
- Rename x1 t1, x2 t2, then clear with commit x1 t1 val 0x10 and rename x4 t3 -> rely x1/x2/x4 = 0, val x1 = 0x10, x4 unrenamed.
- Write x0 via commit (0xFF) and rename (tag 5), with bypass on/off -> rs1_addr=0 gives 0/0. With REG_COMMIT_BYPASS_EN, commit x6 tag 3 val 0x77 while reading x6 -> same-cycle 0x77/0; without the macro -> old val/3.
